// File: rtl/mem_arbiter.sv
// Two-port-to-one RAM arbiter: data requests win, instruction fetch is served otherwise.
// Define MEM_ARB_FAIRNESS_EN to bound instruction starvation with a streak counter.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ramREN,
    output logic        ramWEN,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_range
        $error("mem_arbiter: STARVE_LIMIT must be 1..15");
    end

    state_t state;
    state_t next;
    logic   force_i;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] streak;

    // Streak counts data grants taken while a fetch was waiting.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            streak <= '0;
        end else if (state == IDLE && next == DACC) begin
            if (!iREN)
                streak <= '0;
            else if (streak != LIMIT)
                streak <= streak + 4'd1;
        end else if (state == IDLE && next == IACC) begin
            streak <= '0;
        end
    end

    assign force_i = iREN && (streak == LIMIT);
`else
    assign force_i = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= next;
            if (state != IDLE && ramstate == RAM_ERROR)
                err <= 1'b1;
        end
    end

    always_comb begin
        next     = state;
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        unique case (state)
            IDLE: begin
                if ((dREN || dWEN) && !force_i)
                    next = DACC;
                else if (iREN)
                    next = IACC;
            end
            IACC: begin
                if (!iREN) begin
                    next = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ramstate == RAM_ACCESS) begin
                        ihit  = 1'b1;
                        iload = ramload;
                        next  = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        next = IDLE;
                    end
                end
            end
            DACC: begin
                if (!dREN && !dWEN) begin
                    next = IDLE;
                end else begin
                    ramaddr = daddr;
                    // A write wins when both enables are raised.
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ramstate == RAM_ACCESS) begin
                        dhit  = 1'b1;
                        dload = ramload;
                        next  = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        next = IDLE;
                    end
                end
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a hit scoreboard.
// Grant order is checked through the port recorded in each expected hit.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  ramstate;
    logic [31:0] ramload;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ramREN;
    logic        ramWEN;
    logic        err;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramstate(ramstate), .ramload(ramload),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramREN(ramREN), .ramWEN(ramWEN), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
    endtask

    task automatic push(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (ihit || dhit) begin
            chk("hit_exclusive", {31'b0, ihit && dhit}, 32'd0);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_empty: observed unexpected hit expected none");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("hit_port", {31'b0, dhit}, {31'b0, e.is_d});
                chk("hit_data", dhit ? dload : iload, e.data);
            end
        end
    end

    initial begin
        nRST = 1'b0; iREN = 1'b0; iaddr = '0;
        dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;

        // reset state
        step(); step();
        look();
        chk("rst_ren", {31'b0, ramREN}, 32'd0);
        chk("rst_wen", {31'b0, ramWEN}, 32'd0);
        chk("rst_addr", ramaddr, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        step();
        nRST = 1'b1;

        // instruction only
        iREN = 1'b1; iaddr = 32'h100; ramstate = ACCESS;
        ramload = 32'hDEADBEEF;
        push(1'b0, 32'hDEADBEEF);
        look();
        chk("i0_ren_c0", {31'b0, ramREN}, 32'd0);
        step();
        look();
        chk("i0_ren_c1", {31'b0, ramREN}, 32'd1);
        chk("i0_addr_c1", ramaddr, 32'h100);
        chk("i0_ihit_c1", {31'b0, ihit}, 32'd1);
        step();
        iREN = 1'b0;
        look();
        chk("i0_ren_c2", {31'b0, ramREN}, 32'd0);
        chk("i0_iload_c2", iload, 32'd0);

        // contention: data write first, then fetch
        iREN = 1'b1; iaddr = 32'h104;
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55;
        ramload = 32'h0BADF00D;
        push(1'b1, 32'h0BADF00D);
        push(1'b0, 32'h0BADF00D);
        step();
        look();
        chk("c_wen", {31'b0, ramWEN}, 32'd1);
        chk("c_ren_d", {31'b0, ramREN}, 32'd0);
        chk("c_store", ramstore, 32'h55);
        chk("c_daddr", ramaddr, 32'h200);
        step();
        dWEN = 1'b0;
        step();
        look();
        chk("c_ren_i", {31'b0, ramREN}, 32'd1);
        chk("c_iaddr", ramaddr, 32'h104);
        step();
        iREN = 1'b0;

        // latency: three BUSY cycles, then ACCESS
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        ramload = 32'hCAFEF00D;
        push(1'b1, 32'hCAFEF00D);
        step();
        for (int k = 0; k < 3; k++) begin
            look();
            chk("lat_ren_busy", {31'b0, ramREN}, 32'd1);
            chk("lat_dhit_busy", {31'b0, dhit}, 32'd0);
            chk("lat_dload_busy", dload, 32'd0);
            step();
        end
        ramstate = ACCESS;
        look();
        chk("lat_ren_acc", {31'b0, ramREN}, 32'd1);
        chk("lat_dhit_acc", {31'b0, dhit}, 32'd1);
        step();
        dREN = 1'b0;
        look();
        chk("lat_idle", {31'b0, ramREN}, 32'd0);

        // error during fetch, sticky through a good access
        iREN = 1'b1; iaddr = 32'h400; ramstate = ERROR;
        step();
        look();
        chk("e_ren", {31'b0, ramREN}, 32'd1);
        chk("e_ihit", {31'b0, ihit}, 32'd0);
        step();
        iREN = 1'b0; ramstate = ACCESS;
        look();
        chk("e_err_set", {31'b0, err}, 32'd1);
        dREN = 1'b1; daddr = 32'h500; ramload = 32'h12345678;
        push(1'b1, 32'h12345678);
        step();
        look();
        chk("e_err_hold", {31'b0, err}, 32'd1);
        step();
        dREN = 1'b0;
        look();
        chk("e_err_after", {31'b0, err}, 32'd1);

        // fairness: both requesters held high for six grants
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h600; iaddr = 32'h700;
        ramload = 32'hA5A5A5A5;
`ifdef MEM_ARB_FAIRNESS_EN
        push(1'b1, 32'hA5A5A5A5); push(1'b1, 32'hA5A5A5A5);
        push(1'b0, 32'hA5A5A5A5);
        push(1'b1, 32'hA5A5A5A5); push(1'b1, 32'hA5A5A5A5);
        push(1'b0, 32'hA5A5A5A5);
`else
        for (int k = 0; k < 6; k++) push(1'b1, 32'hA5A5A5A5);
`endif
        for (int k = 0; k < 11; k++) step();
        look();
        step();
        dREN = 1'b0; iREN = 1'b0;
        look();
        chk("f_sb_drained", sb.size(), 32'd0);

        // reset in the middle of a stalled data access
        dREN = 1'b1; daddr = 32'h800; ramstate = BUSY;
        step();
        look();
        chk("r_ren_before", {31'b0, ramREN}, 32'd1);
        nRST = 1'b0;
        step();
        look();
        chk("r_ren", {31'b0, ramREN}, 32'd0);
        chk("r_dhit", {31'b0, dhit}, 32'd0);
        chk("r_addr", ramaddr, 32'd0);
        chk("r_err", {31'b0, err}, 32'd0);
        step();
        nRST = 1'b1; dREN = 1'b0; ramstate = FREE;
        step();
        look();
        chk("end_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
